// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared types and constants for the pipeline hazard controller
package hazard_ctrl_unit_pkg;
  typedef enum logic {ST_RUN, ST_LU_STALL} state_t;
  localparam int REG_ZERO = 0;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// hazard_ctrl_unit_match: flags a destination register read by the ID instruction ($0 never matches)
module hazard_match
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] r,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  output logic             hit
);
  assign hit = (r != REG_W'(REG_ZERO)) && ((use_rs && r == rs) || (use_rt && r == rt));
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use/branch stall, taken-branch flush and data-memory freeze control
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int LU_STALL     = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             ex_mem_mem_read,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_use_rs,
  input  logic             if_id_use_rt,
  input  logic             if_id_branch,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] TO_M1 = WW'(MEM_TIMEOUT - 1);
  state_t state;
  logic [2:0] lu_cnt;
  logic [WW-1:0] wait_cnt;
  logic ex_hit, mem_hit, lu_hit, br_hit, freeze, stall;
  hazard_match #(.REG_W(REG_W)) u_ex_match (
    .r(id_ex_rd), .rs(if_id_rs), .rt(if_id_rt),
    .use_rs(if_id_use_rs), .use_rt(if_id_use_rt), .hit(ex_hit)
  );
  hazard_match #(.REG_W(REG_W)) u_mem_match (
    .r(ex_mem_rd), .rs(if_id_rs), .rt(if_id_rt),
    .use_rs(if_id_use_rs), .use_rt(if_id_use_rt), .hit(mem_hit)
  );
  assign lu_hit = id_ex_mem_read && ex_hit;
  assign br_hit = (BRANCH_IN_ID != 0) && if_id_branch &&
                  ((id_ex_reg_write && ex_hit) || (ex_mem_mem_read && mem_hit));
  assign freeze = dmem_req && !dmem_ready;
  assign stall  = lu_hit || br_hit || (state == ST_LU_STALL);
  // Reset forces the idle pattern so the front end free-runs while held in reset
  assign pc_write     = !rst_n || (!freeze && !stall);
  assign if_id_write  = pc_write;
  assign id_ex_bubble = rst_n && !freeze && stall;
  assign pipe_freeze  = rst_n && freeze;
  assign if_id_flush  = rst_n && !freeze && !stall && branch_taken;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      lu_cnt      <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      if (state == ST_RUN && lu_hit && !freeze && LU_STALL > 1) begin
        state  <= ST_LU_STALL;
        lu_cnt <= 3'(LU_STALL - 1);
      end else if (state == ST_LU_STALL && !freeze) begin
        state  <= (lu_cnt == 3'd1) ? ST_RUN : ST_LU_STALL;
        lu_cnt <= lu_cnt - 3'd1;
      end
      wait_cnt    <= !freeze ? '0 : (wait_cnt == TO) ? wait_cnt : wait_cnt + 1'b1;
      mem_timeout <= mem_timeout || (freeze && wait_cnt == TO_M1);
      if (!pc_write && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed checks on a 3-bubble/branch-in-ID unit and a 1-bubble/no-branch unit
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
  logic [4:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
  logic if_id_use_rs, if_id_use_rt, if_id_branch, branch_taken, dmem_req, dmem_ready;
  logic a_pc, a_ifw, a_bub, a_fl, a_frz, a_to;
  logic [15:0] a_cnt;
  logic b_pc, b_ifw, b_bub, b_fl, b_frz, b_to;
  logic [2:0] b_cnt;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_W(5), .LU_STALL(3), .BRANCH_IN_ID(1), .MEM_TIMEOUT(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .if_id_branch(if_id_branch), .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(a_pc), .if_id_write(a_ifw), .id_ex_bubble(a_bub), .if_id_flush(a_fl),
    .pipe_freeze(a_frz), .mem_timeout(a_to), .stall_count(a_cnt)
  );

  hazard_ctrl_unit #(.REG_W(5), .LU_STALL(1), .BRANCH_IN_ID(0), .MEM_TIMEOUT(255), .CNT_W(3)) u_nb (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_rd(id_ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .if_id_branch(if_id_branch), .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(b_pc), .if_id_write(b_ifw), .id_ex_bubble(b_bub), .if_id_flush(b_fl),
    .pipe_freeze(b_frz), .mem_timeout(b_to), .stall_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = 0;
    ex_mem_mem_read = 0; ex_mem_rd = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_use_rs = 0; if_id_use_rt = 0; if_id_branch = 0; branch_taken = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic load_use_rs8();
    id_ex_mem_read = 1; id_ex_rd = 5'd8; if_id_rs = 5'd8; if_id_use_rs = 1;
  endtask

  initial begin
    clear();
    rst_n = 0;
    load_use_rs8();
    branch_taken = 1;
    #1;
    chk("rst_pc_write", a_pc, 1);
    chk("rst_bubble", a_bub, 0);
    chk("rst_flush", a_fl, 0);
    tick();
    chk("rst_stall_count", a_cnt, 0);
    chk("rst_timeout", a_to, 0);
    clear();
    rst_n = 1;
    #1;
    chk("idle_pc_write", a_pc, 1);
    chk("idle_if_id_write", a_ifw, 1);
    // single-bubble load-use on the LU_STALL=1 unit, first of three on the other
    load_use_rs8();
    #1;
    chk("lu1_pc_write", b_pc, 0);
    chk("lu1_bubble", b_bub, 1);
    chk("lu3_bubble1", a_bub, 1);
    tick();
    clear();
    #1;
    chk("lu1_released", b_pc, 1);
    chk("lu3_bubble2", a_bub, 1);
    chk("lu3_pc_write2", a_pc, 0);
    tick();
    chk("lu3_bubble3", a_bub, 1);
    tick();
    chk("lu3_back_to_run", a_pc, 1);
    chk("lu3_no_bubble", a_bub, 0);
    chk("lu3_stall_count", a_cnt, 3);
    chk("lu1_stall_count", b_cnt, 1);
    // rt-only match, $0 destination, and unused rs
    id_ex_mem_read = 1; id_ex_rd = 5'd9; if_id_rt = 5'd9; if_id_use_rt = 1; if_id_rs = 5'd3;
    #1;
    chk("rt_match_stall", b_pc, 0);
    id_ex_rd = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_use_rs = 1;
    #1;
    chk("zero_reg_a", a_pc, 1);
    chk("zero_reg_b", b_pc, 1);
    id_ex_rd = 5'd9; if_id_rs = 5'd9; if_id_use_rs = 0; if_id_use_rt = 0;
    #1;
    chk("unused_rs", a_pc, 1);
    clear();
    // branch in ID against EX ALU result and MEM load
    if_id_branch = 1; id_ex_reg_write = 1; id_ex_rd = 5'd10; if_id_rs = 5'd10; if_id_use_rs = 1;
    #1;
    chk("br_ex_stall", a_pc, 0);
    chk("br_ex_bubble", a_bub, 1);
    chk("br_ex_nobranch_unit", b_pc, 1);
    id_ex_reg_write = 0; ex_mem_mem_read = 1; ex_mem_rd = 5'd10;
    #1;
    chk("br_mem_stall", a_pc, 0);
    chk("br_mem_nobranch_unit", b_pc, 1);
    ex_mem_mem_read = 0;
    #1;
    chk("br_mem_not_load", a_pc, 1);
    clear();
    // taken-branch flush and stall priority over flush
    branch_taken = 1;
    #1;
    chk("flush_taken", a_fl, 1);
    chk("flush_pc_write", a_pc, 1);
    load_use_rs8();
    #1;
    chk("flush_suppressed", b_fl, 0);
    chk("flush_stall_wins", b_bub, 1);
    clear();
    // freeze during LU_STALL with timeout 3
    load_use_rs8();
    tick();
    clear();
    chk("frz_pre_count_a", a_cnt, 4);
    chk("frz_pre_count_b", b_cnt, 2);
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("frz_pipe_freeze", a_frz, 1);
      chk("frz_no_bubble", a_bub, 0);
      chk("frz_pc_write", a_pc, 0);
      tick();
      chk("frz_timeout", a_to, (i >= 2) ? 1 : 0);
    end
    chk("frz_count_a", a_cnt, 8);
    chk("frz_count_b", b_cnt, 6);
    dmem_ready = 1;
    #1;
    chk("frz_resume_bubble", a_bub, 1);
    chk("frz_resume_nofreeze", a_frz, 0);
    tick();
    chk("timeout_sticky", a_to, 1);
    chk("lu_resume_bubble", a_bub, 1);
    chk("lu_resume_count", a_cnt, 9);
    // reset mid-LU_STALL
    rst_n = 0;
    #1;
    chk("rst_mid_pc_write", a_pc, 1);
    chk("rst_mid_bubble", a_bub, 0);
    tick();
    rst_n = 1;
    clear();
    #1;
    chk("rst_mid_run", a_pc, 1);
    chk("rst_mid_no_bubble", a_bub, 0);
    chk("rst_mid_count", a_cnt, 0);
    chk("rst_mid_timeout", a_to, 0);
    // saturation of a 3-bit stall counter
    load_use_rs8();
    for (int i = 0; i < 9; i++) tick();
    chk("sat_count_b", b_cnt, 7);
    chk("count_a_nine", a_cnt, 9);
    clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the MIPS core; sits beside the ID stage.
- Drives PC, IF/ID, ID/EX and whole-pipe hold/flush controls.
- Detects load-use hazards with correct OR-of-operands matching and $0 exclusion, and supports configurable multi-cycle load-use stall length.
- Adds optional branch-in-ID hazards, taken-branch flush, variable-latency data-memory freeze with timeout, and a saturating stall counter.

Parameters:
- REG_W, 5, register address width
- LU_STALL, 1, bubbles inserted per load-use hazard (1..7)
- BRANCH_IN_ID, 1, 1 = branch compare in ID; enables branch RAW hazard checks
- MEM_TIMEOUT, 255, freeze cycles before mem_timeout asserts (>=1)
- CNT_W, 16, stall_count width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_reg_write  in  1  instruction in EX writes a register
- id_ex_rd  in  REG_W  EX destination (post RegDst mux)
- ex_mem_mem_read  in  1  instruction in MEM is a load
- ex_mem_rd  in  REG_W  MEM destination
- if_id_rs  in  REG_W  ID source rs
- if_id_rt  in  REG_W  ID source rt
- if_id_use_rs  in  1  ID instruction reads rs
- if_id_use_rt  in  1  ID instruction reads rt
- if_id_branch  in  1  ID instruction is beq/bne
- branch_taken  in  1  ID branch resolved taken
- dmem_req  in  1  MEM stage access in progress
- dmem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  zero ID/EX control (insert NOP)
- if_id_flush  out  1  clear IF/ID
- pipe_freeze  out  1  hold EX/MEM and MEM/WB, no writeback
- mem_timeout  out  1  sticky error
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- match(r) = (r != 0) && ((if_id_use_rs && r == if_id_rs) || (if_id_use_rt && r == if_id_rt)).
- lu_hit = id_ex_mem_read && match(id_ex_rd).
- br_hit = BRANCH_IN_ID && if_id_branch && ((id_ex_reg_write && match(id_ex_rd)) || (ex_mem_mem_read && match(ex_mem_rd))).
- freeze = dmem_req && !dmem_ready.
- FSM states RUN, LU_STALL; 3-bit lu_cnt.
  - RUN: lu_hit && !freeze && LU_STALL>1 -> LU_STALL with lu_cnt = LU_STALL-1.
  - LU_STALL: stall asserted regardless of inputs; lu_cnt decrements each non-freeze cycle; lu_cnt==1 and decrementing -> RUN.
  - LU_STALL=1: no state change; the hazard clears naturally as the bubble advances.
- stall = lu_hit || br_hit || (state == LU_STALL).
- Output priority: freeze > stall > flush.
  - freeze: pc_write=0, if_id_write=0, id_ex_bubble=0, pipe_freeze=1, if_id_flush=0.
  - stall (no freeze): pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_freeze=0, if_id_flush=0.
  - else: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=branch_taken, pipe_freeze=0.
- Branch decision with stall set is invalid and ignored.
- Outputs are combinational from inputs plus state; 0-cycle latency.
- wait_cnt counts consecutive freeze cycles and clears when freeze drops.
  - wait_cnt reaching MEM_TIMEOUT sets mem_timeout. It stays set until reset; freeze behaviour is unchanged.
  - wait_cnt saturates.
- stall_count increments each cycle pc_write==0 and holds at all-ones.
- Reset (rst_n=0 at edge): state=RUN, lu_cnt=0, wait_cnt=0, mem_timeout=0, stall_count=0.
- While rst_n is low, outputs are forced to: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pipe_freeze=0.
- Reset mid-LU_STALL or mid-freeze aborts immediately.

Decomposition:
- Shared package holds:
  - state typedef (RUN, LU_STALL)
  - REG_ZERO constant
  - default timeout and counter-width constants
- One sub-module, hazard_match: combinational match(r) for one destination, instantiated twice.

Test Plan:
- Load $t0 in EX, ID reads rs=$t0, LU_STALL=1 -> 1 cycle pc_write=0, id_ex_bubble=1; rt-only match also stalls; rd=$0 never stalls.
- LU_STALL=3 with load hit -> exactly 3 consecutive bubbles, then RUN, and stall_count=3.
- beq rs matches EX ALU rd -> 1 stall; beq matches MEM load rd -> 1 more stall; BRANCH_IN_ID=0 -> no stall.
- branch_taken=1 with no hazard -> if_id_flush=1 for 1 cycle; branch_taken=1 with lu_hit -> flush=0, stall wins.
- dmem_req=1, dmem_ready=0 for 4 cycles during LU_STALL -> pipe_freeze=1 for 4 cycles and lu_cnt paused; MEM_TIMEOUT=3 -> mem_timeout rises on the 3rd freeze cycle and stays high.
- rst_n=0 mid-LU_STALL -> next edge state=RUN, counters 0, outputs at idle values.
